rr_arbiter_3x8: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters. Holds the winning

---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_arbiter_3x8_dec.sv | 16 +
 rtl/rr_arbiter_3x8.sv | 105 ++++++++++
 tb/tb_rr_arbiter_3x8.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for rr_arbiter_3x8.
// Exports N_REQ, IDX_W, arb_state_t, arb_idx_t and rr_pick().
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [IDX_W-1:0] arb_idx_t;

  // Returns {found, idx}: the first set req bit scanning
  // ptr+1, ptr+2 .. ptr (mod 8). The loop runs from the far
  // end so the nearest hit is the last one assigned.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input arb_idx_t         ptr
  );
    logic [IDX_W:0] r;
    arb_idx_t       c;
    r = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      c = ptr + arb_idx_t'(i);
      if (req[c]) r = {1'b1, c};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_3x8_dec.sv
// Enabled 3-to-8 one-hot decoder driving the arbiter grant vector.
// Ports: A index, E enable, D one-hot output (zero when E=0).
module one_hot_decoder_3x8
  import arb_pkg::*;
(
  input  arb_idx_t   A,
  input  logic       E,
  output logic [7:0] D
);

  always_comb begin
    D = '0;
    if (E) D[A] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_3x8.sv
// Round-robin arbiter, 8 requesters, registered 3-bit owner index.
// Ports: clk, rst_n, en, req[7:0] -> gnt[7:0], gnt_idx, gnt_vld,
// timeout (only when ARB_TIMEOUT_EN is defined, with MAX_HOLD).
module rr_arbiter_3x8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output arb_idx_t         gnt_idx,
  output logic             gnt_vld
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  arb_state_t     state;
  arb_idx_t       ptr;
  logic [IDX_W:0] pick_idle;
  logic [IDX_W:0] pick_rel;
  logic           drop;
  logic           revoke;
  logic           rel;

  // From IDLE scan after the last owner; on release scan
  // after the current owner so it ends up lowest priority.
  assign pick_idle = rr_pick(req, ptr);
  assign pick_rel  = rr_pick(req, gnt_idx);
  assign drop      = !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       others;

  assign others = |(req & ~(8'd1 << gnt_idx));
  assign revoke = (state == GRANT) && !drop && others &&
                  (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign revoke = 1'b0;
`endif

  assign rel = (state == GRANT) && (drop || revoke);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      ptr      <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (en && pick_idle[IDX_W]) begin
            state   <= GRANT;
            gnt_idx <= pick_idle[IDX_W-1:0];
            gnt_vld <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= gnt_idx;
            if (en && pick_rel[IDX_W]) begin
              gnt_idx <= pick_rel[IDX_W-1:0];
            end else begin
              state   <= IDLE;
              gnt_vld <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
        end
      endcase
`ifdef ARB_TIMEOUT_EN
      timeout <= revoke;
      // Any fresh grant starts from zero; saturate so a
      // large MAX_HOLD can never wrap the count.
      if (state != GRANT || rel)
        hold_cnt <= '0;
      else if (others && hold_cnt != 8'hFF)
        hold_cnt <= hold_cnt + 8'd1;
`endif
    end
  end

  one_hot_decoder_3x8 u_dec (
    .A (gnt_idx),
    .E (gnt_vld),
    .D (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_3x8.sv
// Scoreboard bench for rr_arbiter_3x8.
// Define ARB_TIMEOUT_EN to also exercise forced release.
module tb_rr_arbiter_3x8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic       to;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter_3x8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );
`else
  rr_arbiter_3x8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );
`endif

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare
  // what the DUT shows just after the edge.
  task automatic step(
    input string      tag,
    input logic [7:0] r,
    input logic       e,
    input logic [7:0] g,
    input logic       to = 1'b0
  );
    exp_t x;
    logic [2:0] xi;
    req = r;
    en  = e;
    sb.push_back('{tag, g, to});
    @(posedge clk);
    #1;
    x  = sb.pop_front();
    xi = '0;
    for (int i = 0; i < 8; i++)
      if (x.gnt[i]) xi = 3'(i);
    check({x.tag, ".gnt"}, 32'(gnt), 32'(x.gnt));
    check({x.tag, ".vld"}, 32'(gnt_vld), 32'(x.gnt != 0));
    if (x.gnt != 0)
      check({x.tag, ".idx"}, 32'(gnt_idx), 32'(xi));
`ifdef ARB_TIMEOUT_EN
    check({x.tag, ".to"}, 32'(timeout), 32'(x.to));
`endif
  endtask

  // gnt must always be the decode of gnt_vld/gnt_idx
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", 32'(gnt),
            32'(gnt_vld ? (8'd1 << gnt_idx) : 8'd0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.vld", 32'(gnt_vld), 32'h0);
    check("rst.idx", 32'(gnt_idx), 32'h0);
`ifdef ARB_TIMEOUT_EN
    check("rst.to", 32'(timeout), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: first winner is req[0], then next in line
    step("t1.first", 8'hFF, 1'b1, 8'h01);
    step("t1.next",  8'hFE, 1'b1, 8'h02);
    step("t1.idle",  8'h00, 1'b1, 8'h00);

    // 2: wrap 7 -> 0 with no bubble
    step("t2.own7",  8'h81, 1'b1, 8'h80);
    step("t2.wrap",  8'h01, 1'b1, 8'h01);
    step("t2.idle",  8'h00, 1'b1, 8'h00);

    // 3: en=0 blocks new grants
    for (int i = 0; i < 10; i++)
      step("t3.hold0", 8'h10, 1'b0, 8'h00);
    step("t3.en",    8'h10, 1'b1, 8'h10);
    step("t3.idle",  8'h00, 1'b1, 8'h00);

    // 4: async reset mid-grant
    step("t4.g2",    8'h04, 1'b1, 8'h04);
    step("t4.hold",  8'h04, 1'b1, 8'h04);
    #2;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    check("t4.async.gnt", 32'(gnt), 32'h0);
    check("t4.async.vld", 32'(gnt_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t4.rel.gnt", 32'(gnt), 32'h0);
    step("t4.win0",  8'h05, 1'b1, 8'h01);
    step("t4.idle",  8'h00, 1'b1, 8'h00);

    // 5: drop and re-raise loses to waiting req[5]
    step("t5.own3",  8'h08, 1'b1, 8'h08);
    step("t5.cmp",   8'h28, 1'b1, 8'h08);
    step("t5.to5",   8'h20, 1'b1, 8'h20);
    step("t5.rer",   8'h28, 1'b1, 8'h20);
    step("t5.back3", 8'h08, 1'b1, 8'h08);
    step("t5.idle",  8'h00, 1'b1, 8'h00);

    // single requester re-granted after release
    step("s.g",      8'h08, 1'b1, 8'h08);
    step("s.rel",    8'h00, 1'b1, 8'h00);
    step("s.re",     8'h08, 1'b1, 8'h08);
    step("s.idle",   8'h00, 1'b1, 8'h00);

    // release with en=0 goes idle
    step("e.g4",     8'h18, 1'b1, 8'h10);
    step("e.rel",    8'h08, 1'b0, 8'h00);
    step("e.wait",   8'h08, 1'b0, 8'h00);
    step("e.en",     8'h08, 1'b1, 8'h08);
    step("e.idle",   8'h00, 1'b1, 8'h00);

`ifdef ARB_TIMEOUT_EN
    // 6: MAX_HOLD=4 forced release, lone owner kept
    for (int i = 0; i < 4; i++)
      step("t6.hold", 8'h03, 1'b1, 8'h01);
    step("t6.revoke", 8'h03, 1'b1, 8'h02, 1'b1);
    step("t6.after",  8'h03, 1'b1, 8'h02);
    step("t6.lone",   8'h01, 1'b1, 8'h01);
    for (int i = 0; i < 20; i++)
      step("t6.keep", 8'h01, 1'b1, 8'h01);
    step("t6.idle",   8'h00, 1'b1, 8'h00);
`endif

    check("sb.empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
